cacheline_adaptor: RTL and testbench

Converts 256-bit cacheline transactions from the cache/arbiter side into four 64-bit burst beats on the physical-memory side, and assembles returned beats back into a line. It sits between the memory arbiter and main memory. It is the responder to the arbiter's line requests and the initiator of memory bursts.

---
 rtl/cacheline_adaptor_pkg.sv | 22 ++
 rtl/cacheline_adaptor_watchdog.sv | 38 +++
 rtl/cacheline_adaptor.sv | 144 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types for the cacheline adaptor: FSM state, line/beat widths, address alignment.
// Pure declarations, no latency; no flow control.
package cacheline_adaptor_pkg;

    localparam int CLA_BEATS       = 4;
    localparam int CLA_BURST_WIDTH = 64;
    localparam int CLA_LINE_WIDTH  = CLA_BEATS * CLA_BURST_WIDTH;

    typedef logic [255:0] cacheline_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } cla_state_t;

    function automatic logic [31:0] cla_align(input logic [31:0] addr);
        return addr & ~32'h0000_001f;
    endfunction

endpackage

// File: rtl/cacheline_adaptor_watchdog.sv
// cla_watchdog: counts consecutive stalled beat cycles; fire_o is combinational in the limit cycle.
// Zero latency on fire_o; count clears on any beat or when no transfer is active.
module cla_watchdog
    import cacheline_adaptor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic beat_i,
    output logic fire_o
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         stall;

    assign stall  = active_i && !beat_i;
    assign fire_o = stall && (cnt_q == W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (stall && !fire_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cacheline_adaptor.sv
// Splits 256-bit line reads/writes into four 64-bit memory beats; resp_o 5 cycles after request at best.
// Beats advance only on resp_i; CLA_TIMEOUT_EN adds a stall watchdog with err_o.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int BEATS = CLA_BEATS
`ifdef CLA_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                address_i,
    input  logic                       read_i,
    input  logic                       write_i,
    input  logic [CLA_LINE_WIDTH-1:0]  line_i,
    output logic [CLA_LINE_WIDTH-1:0]  line_o,
    output logic                       resp_o,
    output logic [31:0]                address_o,
    output logic                       read_o,
    output logic                       write_o,
    output logic [CLA_BURST_WIDTH-1:0] burst_o,
    input  logic [CLA_BURST_WIDTH-1:0] burst_i,
    input  logic                       resp_i
`ifdef CLA_TIMEOUT_EN
    ,
    output logic                       err_o
`endif
);

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    cla_state_t  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    cacheline_t  rd_buf_q, rd_buf_d;
    cacheline_t  wr_buf_q, wr_buf_d;
    logic        wd_fire;

`ifdef CLA_TIMEOUT_EN
    cla_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active_i(state_q == READ || state_q == WRITE),
        .beat_i  (resp_i),
        .fire_o  (wd_fire)
    );
    assign err_o = wd_fire;
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read has priority when both requests are presented together.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (read_i) begin
                    state_d = READ;
                end else if (write_i) begin
                    state_d = WRITE;
                end
            end
            READ, WRITE: begin
                if (resp_i && cnt_q == LAST_BEAT) begin
                    state_d = DONE;
                end else if (wd_fire) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_o    = (state_q == READ);
        write_o   = (state_q == WRITE);
        resp_o    = (state_q == DONE);
        address_o = addr_q;
        line_o    = rd_buf_q;
        burst_o   = '0;
        if (state_q == WRITE) begin
            burst_o = wr_buf_q[{cnt_q, 6'b0} +: CLA_BURST_WIDTH];
        end
    end

    // Separate read/write buffers so line_o keeps the last read line across writes.
    always_comb begin
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rd_buf_d = rd_buf_q;
        wr_buf_d = wr_buf_q;
        unique case (state_q)
            IDLE: begin
                if (read_i || write_i) begin
                    addr_d = cla_align(address_i);
                    cnt_d  = 2'd0;
                end
                if (!read_i && write_i) begin
                    wr_buf_d = line_i;
                end
            end
            READ: begin
                if (resp_i) begin
                    rd_buf_d[{cnt_q, 6'b0} +: CLA_BURST_WIDTH] = burst_i;
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            addr_q   <= '0;
            rd_buf_q <= '0;
            wr_buf_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rd_buf_q <= rd_buf_d;
            wr_buf_q <= wr_buf_d;
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: expected lines queued at request, checked at resp_o.
// Inputs driven 1 time unit after the rising edge; monitor samples on the falling edge.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;
`ifdef CLA_TIMEOUT_EN
    logic         err_o;
`endif

    always #5 clk = ~clk;

`ifdef CLA_TIMEOUT_EN
    cacheline_adaptor #(.TIMEOUT_CYCLES(8)) dut (
`else
    cacheline_adaptor dut (
`endif
        .clk      (clk),
        .rst_n    (rst_n),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .line_i   (line_i),
        .line_o   (line_o),
        .resp_o   (resp_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .burst_o  (burst_o),
        .burst_i  (burst_i),
        .resp_i   (resp_i)
`ifdef CLA_TIMEOUT_EN
        ,
        .err_o    (err_o)
`endif
    );

    typedef struct {
        bit           is_rd;
        logic [255:0] line;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           wbeat   = 0;
    logic [255:0] last_rd;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: checks every accepted write beat and every completion against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (write_o && resp_i) begin
                if (sb_q.size() > 0) begin
                    check("wr_beat", 256'(burst_o), 256'(sb_q[0].line[wbeat*64 +: 64]));
                end
                wbeat++;
            end
            if (resp_o) begin
                if (sb_q.size() == 0) begin
                    check("unexp_resp", 256'(resp_o), 256'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.is_rd) begin
                        check("rd_line", line_o, mon_e.line);
                    end else begin
                        check("wr_beat_cnt", 256'(wbeat), 256'(4));
                    end
                    wbeat = 0;
                end
            end
        end
    end

    // One line transfer; pat[i] is resp_i in transfer cycle i, 1 beyond plen.
    task automatic xfer(input bit is_rd, input bit both, input logic [31:0] addr,
                        input logic [255:0] line, input logic [15:0] pat, input int plen);
        int   beats = 0;
        int   idx   = 0;
        exp_t e;
        e.is_rd = is_rd;
        e.line  = line;
        sb_q.push_back(e);
        @(posedge clk); #1;
        address_i = addr;
        read_i    = is_rd;
        write_i   = !is_rd || both;
        line_i    = is_rd ? {8{$urandom}} : line;
        @(posedge clk); #1;
        check("address_o", 256'(address_o), 256'(addr & ~32'h1f));
        check("read_o", 256'(read_o), 256'(is_rd));
        check("write_o", 256'(write_o), 256'(!is_rd));
        while (beats < 4 && idx < 64) begin
            resp_i  = (idx < plen) ? pat[idx[3:0]] : 1'b1;
            burst_i = (is_rd && resp_i) ? line[beats*64 +: 64] : {$urandom, $urandom};
            if (!is_rd) begin
                check("burst_o", 256'(burst_o), 256'(line[beats*64 +: 64]));
            end else if (both) begin
                check("both_write_o", 256'(write_o), 256'(0));
            end
            if (resp_i) beats++;
            idx++;
            @(posedge clk); #1;
        end
        resp_i  = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        check("resp_o", 256'(resp_o), 256'(1));
        @(posedge clk); #1;
        check("resp_pulse", 256'(resp_o), 256'(0));
        check("sb_empty", 256'(sb_q.size()), 256'(0));
        if (is_rd) last_rd = line;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] l1, lw, l3, l4, l5;
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        lw = {64'hDDCC_BBAA_DDCC_BB04, 64'hDDCC_BBAA_DDCC_BB03,
              64'hDDCC_BBAA_DDCC_BB02, 64'hDDCC_BBAA_DDCC_BB01};
        l3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0};
        l4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        l5 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

        rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0; address_i = '0;
        line_i = '0; burst_i = '0; resp_i = 1'b0; last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_address_o", 256'(address_o), 256'(0));
        check("rst_read_o", 256'(read_o), 256'(0));
        check("rst_write_o", 256'(write_o), 256'(0));
        check("rst_resp_o", 256'(resp_o), 256'(0));
        check("rst_line_o", line_o, 256'(0));
        check("rst_burst_o", 256'(burst_o), 256'(0));
`ifdef CLA_TIMEOUT_EN
        check("rst_err_o", 256'(err_o), 256'(0));
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        xfer(1'b1, 1'b0, 32'h0000_1234, l1, 16'h0, 0);
        xfer(1'b0, 1'b0, 32'h0000_8007, lw, 16'b10_1101, 6);
        check("line_hold", line_o, l1);
        xfer(1'b1, 1'b1, 32'hABCD_EF5F, l3, 16'b0110_0101, 8);

        // Abort a read after two beats with an asynchronous reset.
        @(posedge clk); #1;
        read_i = 1'b1; address_i = 32'h0000_4040;
        @(posedge clk); #1;
        resp_i = 1'b1; burst_i = 64'hAAAA_0000_0000_0001;
        @(posedge clk); #1;
        burst_i = 64'hAAAA_0000_0000_0002;
        @(posedge clk); #1;
        resp_i = 1'b0;
        check("pre_abort_read_o", 256'(read_o), 256'(1));
        rst_n = 1'b0;
        #1;
        check("abort_read_o", 256'(read_o), 256'(0));
        check("abort_resp_o", 256'(resp_o), 256'(0));
        check("abort_line_o", line_o, 256'(0));
        read_i = 1'b0;
        @(posedge clk); #1;
        check("abort_resp_hold", 256'(resp_o), 256'(0));
        rst_n = 1'b1;

        xfer(1'b1, 1'b0, 32'h1000_001F, l4, 16'b1001_0011, 8);
        xfer(1'b0, 1'b0, 32'hFFFF_FFE0, l5, 16'h0, 0);
        check("line_hold2", line_o, l4);

`ifdef CLA_TIMEOUT_EN
        @(posedge clk); #1;
        read_i = 1'b1; address_i = 32'h0000_2000; resp_i = 1'b0;
        @(posedge clk); #1;
        for (int s = 1; s <= 8; s++) begin
            check("err_o_stall", 256'(err_o), 256'(s == 8));
            check("stall_resp_o", 256'(resp_o), 256'(0));
            if (s == 8) read_i = 1'b0;
            @(posedge clk); #1;
        end
        check("to_read_o", 256'(read_o), 256'(0));
        check("to_err_clear", 256'(err_o), 256'(0));
        check("to_resp_o", 256'(resp_o), 256'(0));
        xfer(1'b1, 1'b0, 32'h0000_3000, l3, 16'b0111_1011, 8);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
